fetch_stage: RTL

- Pipeline IF stage plus the IF/ID register for the 5-stage RV32I core.
- Holds the PC and selects the next PC: sequential, or the redirect target from EX.
- Drives the instruction-memory address and captures the fetched word into the decode-stage register.
- InstrD[31:7] feeds the decode-stage immediate extender; InstrD feeds the control decoder and register file.

---
 rtl/fetch_stage.sv | 95 +++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I IF stage with PC register and IF/ID pipeline register
//
// Purpose:
//   Holds the fetch PC and picks its next value: reset, an EX redirect, hold,
//   or sequential +4. It drives the instruction-memory address straight from
//   the PC. It captures the combinationally read word into the IF/ID register,
//   together with its PC, PC+4 and a valid flag.
//
// Ports:
//   clk        in   system clock; all state updates on the rising edge
//   rst        in   synchronous active-high reset
//   StallF     in   hold PCF
//   StallD     in   hold the IF/ID register
//   FlushD     in   replace the IF/ID contents with a bubble
//   PCSrcE     in   taken branch/jump resolved in EX
//   PCTargetE  in   redirect target from EX
//   imem_addr  out  instruction-memory read address (= PCF)
//   imem_rdata in   instruction word read combinationally at imem_addr
//   PCF        out  current fetch PC
//   InstrD     out  instruction in decode
//   PCD        out  PC of InstrD
//   PCPlus4D   out  PCD + 4, the link value for JAL/JALR
//   ValidD     out  1 = InstrD was really fetched, 0 = bubble

module fetch_stage #(
   parameter int                     ADDRESS_WIDTH = 32,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
   parameter logic [ADDRESS_WIDTH-1:0] NOP_INSTR   = 32'h0000_0013
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     StallF,
   input  logic                     StallD,
   input  logic                     FlushD,
   input  logic                     PCSrcE,
   input  logic [ADDRESS_WIDTH-1:0] PCTargetE,
   output logic [ADDRESS_WIDTH-1:0] imem_addr,
   input  logic [ADDRESS_WIDTH-1:0] imem_rdata,
   output logic [ADDRESS_WIDTH-1:0] PCF,
   output logic [ADDRESS_WIDTH-1:0] InstrD,
   output logic [ADDRESS_WIDTH-1:0] PCD,
   output logic [ADDRESS_WIDTH-1:0] PCPlus4D,
   output logic                     ValidD
);

   localparam logic [ADDRESS_WIDTH-1:0] C_FOUR = ADDRESS_WIDTH'(4);

   logic [ADDRESS_WIDTH-1:0] r_pcf;
   logic [ADDRESS_WIDTH-1:0] r_instr_d;
   logic [ADDRESS_WIDTH-1:0] r_pc_d;
   logic [ADDRESS_WIDTH-1:0] r_pc_plus4_d;
   logic                     r_valid_d;

   logic [ADDRESS_WIDTH-1:0] w_pc_plus4;
   logic [ADDRESS_WIDTH-1:0] w_target_aligned;

   // The adder is truncated to ADDRESS_WIDTH, so the top word wraps to zero.
   assign w_pc_plus4       = r_pcf + C_FOUR;
   assign w_target_aligned = {PCTargetE[ADDRESS_WIDTH-1:2], 2'b00};

   // A redirect beats StallF: the stall was raised for the wrong-path fetch,
   // and that fetch is being discarded.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pcf <= RESET_PC;
      end else if (PCSrcE) begin
         r_pcf <= w_target_aligned;
      end else if (!StallF) begin
         r_pcf <= w_pc_plus4;
      end
   end

   // A flush beats StallD, so a bubble can always be injected.
   always_ff @(posedge clk) begin
      if (rst || FlushD) begin
         r_instr_d    <= NOP_INSTR;
         r_pc_d       <= '0;
         r_pc_plus4_d <= '0;
         r_valid_d    <= 1'b0;
      end else if (!StallD) begin
         r_instr_d    <= imem_rdata;
         r_pc_d       <= r_pcf;
         r_pc_plus4_d <= w_pc_plus4;
         r_valid_d    <= 1'b1;
      end
   end

   assign imem_addr = r_pcf;
   assign PCF       = r_pcf;
   assign InstrD    = r_instr_d;
   assign PCD       = r_pc_d;
   assign PCPlus4D  = r_pc_plus4_d;
   assign ValidD    = r_valid_d;

endmodule
